// File: rtl/ibex_data_mem_responder.sv
// ibex_data_mem_responder: word-organised data memory on the core's data req/gnt/rvalid port.
// Define DMEM_RAND_STALL_EN to add 0-3 LFSR-driven extra grant stall cycles per request.
module ibex_data_mem_responder #(
   parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
   parameter int          MEM_WORDS      = 1024,
   parameter int          GNT_LATENCY    = 0,
   parameter int          RVALID_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        busy_o
);

   localparam int IW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, STALL, RESP} state_t;

   state_t        state;
   logic [15:0]   stall_cnt;
   logic [15:0]   resp_cnt;
   logic          rvalid_q;
   logic [31:0]   resp_data;
   logic [31:0]   hold_data;
   logic [31:0]   mem [MEM_WORDS];

   logic [32:0]   addr_ext;
   logic [32:0]   base_ext;
   logic [32:0]   limit_ext;
   logic [31:0]   offset;
   logic [IW-1:0] idx;
   logic          in_range;
   logic          accept;
   logic          gnt;
   logic [15:0]   lat;

   // Address decode on 33 bits so the window never wraps past 32'hFFFF_FFFF
   assign addr_ext  = {1'b0, data_addr_i};
   assign base_ext  = {1'b0, ADDR_BASE};
   assign limit_ext = base_ext + 33'(4 * MEM_WORDS);
   assign in_range  = (addr_ext >= base_ext) && (addr_ext < limit_ext);
   assign offset    = data_addr_i - ADDR_BASE;
   assign idx       = IW'(offset >> 2);

`ifdef DMEM_RAND_STALL_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign lat     = 16'(GNT_LATENCY) + {14'd0, lfsr[1:0]};

   // Free-running Fibonacci LFSR supplying extra grant stall cycles
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr_fb};
   end
`else
   assign lat = 16'(GNT_LATENCY);
`endif

   // A new request may be taken when idle or in the rvalid cycle of the previous one
   assign accept = (state == IDLE) || ((state == RESP) && rvalid_q);
   assign gnt    = !rst && data_req_i &&
                   ((accept && (lat == 16'd0)) ||
                    ((state == STALL) && (stall_cnt == 16'd0)));

   assign data_gnt_o    = gnt;
   assign data_err_o    = gnt && !in_range;
   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rvalid_q ? resp_data : hold_data;
   assign busy_o        = (state != IDLE) || data_req_i;

   // Handshake FSM: grant stall, response latency and single-cycle rvalid
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         stall_cnt <= 16'd0;
         resp_cnt  <= 16'd0;
         rvalid_q  <= 1'b0;
      end else if (gnt) begin
         state    <= RESP;
         resp_cnt <= 16'(RVALID_LATENCY - 1);
         rvalid_q <= (RVALID_LATENCY == 1);
      end else begin
         rvalid_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (data_req_i) begin
                  state     <= STALL;
                  stall_cnt <= lat - 16'd1;
               end
            end
            STALL: begin
               if (!data_req_i) state <= IDLE;
               else             stall_cnt <= stall_cnt - 16'd1;
            end
            RESP: begin
               if (rvalid_q) begin
                  if (data_req_i) begin
                     state     <= STALL;
                     stall_cnt <= lat - 16'd1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  resp_cnt <= resp_cnt - 16'd1;
                  rvalid_q <= (resp_cnt == 16'd1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Byte-lane writes committed at the end of the grant cycle
   always_ff @(posedge clk) begin
      if (gnt && data_we_i && in_range) begin
         for (int n = 0; n < 4; n++) begin
            if (data_be_i[n]) mem[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
         end
      end
   end

   // Response capture at grant; last response held for the output between rvalids
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_data <= 32'd0;
         hold_data <= 32'd0;
      end else begin
         if (gnt) resp_data <= (!data_we_i && in_range) ? mem[idx] : 32'd0;
         if (rvalid_q) hold_data <= resp_data;
      end
   end

endmodule
